// File: rtl/imem_loader.sv
// Byte-stream loader and clocked fetch port for the datapath's 32-word instruction store.
// Latency: one cycle on fetch; a load of N words needs at least 4*N accepted bytes; the datapath is held in reset until the load completes.
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              load_start_i,
    input  logic [5:0]        load_count_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    output logic              in_ready_o,
    input  logic [31:0]       rd_addr_i,
    output logic [31:0]       rd_instr_o,
    output logic              cpu_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t             state_q;
    logic [5:0]         cnt_q;
    logic [ADDR_W-1:0]  ptr_q;
    logic [1:0]         byte_q;
    logic [23:0]        asm_q;
    logic               in_ready_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic               cpu_rst_q;
    logic [31:0]        rd_instr_q;
    logic [31:0]        mem_q [DEPTH];

    logic               count_ok;
    logic               byte_xfer;
    logic               word_done;
    logic               last_word;
    logic [31:0]        word_d;
    logic [5:0]         ptr_d;
    logic [ADDR_W-1:0]  rd_idx;
    logic [31-ADDR_W:0] unused_rd_addr_hi;

    assign rd_idx            = rd_addr_i[ADDR_W-1:0];
    assign unused_rd_addr_hi = rd_addr_i[31:ADDR_W];

    always_comb begin
        count_ok  = (load_count_i != 6'd0) && (load_count_i <= 6'(DEPTH));
        byte_xfer = (state_q == S_LOAD) && in_valid_i && in_ready_q;
        word_done = byte_xfer && (byte_q == 2'd3);
        word_d    = {asm_q, in_data_i};
        // Six bits so that a full 32-word load compares against 32 without wrapping.
        ptr_d     = {1'b0, ptr_q} + 6'd1;
        last_word = word_done && (ptr_d == cnt_q);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            byte_q     <= '0;
            asm_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_rst_q  <= 1'b1;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE, S_RUN: begin
                    if (load_start_i) begin
                        if (count_ok) begin
                            state_q    <= S_LOAD;
                            cnt_q      <= load_count_i;
                            ptr_q      <= '0;
                            byte_q     <= '0;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b0;
                            cpu_rst_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (byte_xfer) begin
                        asm_q  <= {asm_q[15:0], in_data_i};
                        byte_q <= byte_q + 2'd1;
                    end
                    if (word_done) begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                    if (last_word) begin
                        state_q    <= S_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        cpu_rst_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    cpu_rst_q  <= 1'b1;
                end
            endcase
        end
    end

    // Non-blocking read of mem_q gives old data when a fetch hits the entry being written.
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
            rd_instr_q <= '0;
        end else begin
            if (word_done) begin
                mem_q[ptr_q] <= word_d;
            end
            rd_instr_q <= mem_q[rd_idx];
        end
    end

    assign in_ready_o = in_ready_q;
    assign rd_instr_o = rd_instr_q;
    assign cpu_rst_o  = cpu_rst_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, loads, throttling, illegal counts, reload and mid-load reset.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        load_start_i = 1'b0;
    logic [5:0]  load_count_i = '0;
    logic        in_valid_i = 1'b0;
    logic [7:0]  in_data_i = '0;
    logic        in_ready_o;
    logic [31:0] rd_addr_i = '0;
    logic [31:0] rd_instr_o;
    logic        cpu_rst_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int n_cmp  = 0;
    int n_fail = 0;

    imem_loader dut (
        .clock       (clock),
        .rst         (rst),
        .load_start_i(load_start_i),
        .load_count_i(load_count_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .rd_addr_i   (rd_addr_i),
        .rd_instr_o  (rd_instr_o),
        .cpu_rst_o   (cpu_rst_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clock = ~clock;

    // Advance one edge; inputs are driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic read_word(input logic [31:0] addr, output logic [31:0] data);
        rd_addr_i = addr;
        tick();
        data = rd_instr_o;
    endtask

    task automatic start_load(input logic [5:0] cnt);
        load_start_i = 1'b1;
        load_count_i = cnt;
        tick();
        load_start_i = 1'b0;
        load_count_i = '0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid_i = 1'b1;
        in_data_i  = b;
        tick();
        in_valid_i = 1'b0;
        in_data_i  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        n_cmp++; if (cpu_rst_o !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_rst got=%b want=1", cpu_rst_o); end
        n_cmp++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b want=0", in_ready_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b want=0", err_o); end
        n_cmp++; if (rd_instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_rd_instr got=%h want=0", rd_instr_o); end
        for (int a = 0; a < 32; a++) begin
            read_word(32'(a), d);
            n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mem[%0d] got=%h want=00000000", a, d); end
        end
    endtask

    task automatic test_two_word();
        logic [7:0]  bytes [8] = '{8'h8C, 8'h11, 8'h00, 8'h08, 8'h8C, 8'h12, 8'h00, 8'h04};
        logic [31:0] d;
        start_load(6'd2);
        n_cmp++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL two_in_ready got=%b want=1", in_ready_o); end
        n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL two_busy got=%b want=1", busy_o); end
        for (int i = 0; i < 8; i++) begin
            send_byte(bytes[i]);
            if (i == 6) begin
                n_cmp++; if (done_o !== 1'b0 || cpu_rst_o !== 1'b1) begin n_fail++; $display("FAIL two_early_done done=%b cpu_rst=%b want 0/1", done_o, cpu_rst_o); end
            end
        end
        n_cmp++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL two_done got=%b want=1", done_o); end
        n_cmp++; if (cpu_rst_o !== 1'b0) begin n_fail++; $display("FAIL two_cpu_rst got=%b want=0", cpu_rst_o); end
        n_cmp++; if (busy_o !== 1'b0 || in_ready_o !== 1'b0) begin n_fail++; $display("FAIL two_idle_flags busy=%b in_ready=%b want 0/0", busy_o, in_ready_o); end
        read_word(32'd1, d);
        n_cmp++; if (d !== 32'h8C120004) begin n_fail++; $display("FAIL two_mem1 got=%h want=8c120004", d); end
        read_word(32'd0, d);
        n_cmp++; if (d !== 32'h8C110008) begin n_fail++; $display("FAIL two_mem0 got=%h want=8c110008", d); end
        // Upper address bits are ignored: 0x21 aliases word 1.
        read_word(32'h0000_0021, d);
        n_cmp++; if (d !== 32'h8C120004) begin n_fail++; $display("FAIL two_alias got=%h want=8c120004", d); end
    endtask

    task automatic test_reload();
        logic [7:0]  bytes [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        logic [31:0] d;
        start_load(6'd1);
        n_cmp++; if (cpu_rst_o !== 1'b1) begin n_fail++; $display("FAIL reload_cpu_rst got=%b want=1", cpu_rst_o); end
        n_cmp++; if (done_o !== 1'b0 || busy_o !== 1'b1 || in_ready_o !== 1'b1) begin n_fail++; $display("FAIL reload_flags done=%b busy=%b in_ready=%b want 0/1/1", done_o, busy_o, in_ready_o); end
        for (int i = 0; i < 4; i++) send_byte(bytes[i]);
        n_cmp++; if (done_o !== 1'b1 || cpu_rst_o !== 1'b0) begin n_fail++; $display("FAIL reload_done done=%b cpu_rst=%b want 1/0", done_o, cpu_rst_o); end
        read_word(32'd0, d);
        n_cmp++; if (d !== 32'hAABBCCDD) begin n_fail++; $display("FAIL reload_mem0 got=%h want=aabbccdd", d); end
        read_word(32'd1, d);
        n_cmp++; if (d !== 32'h8C120004) begin n_fail++; $display("FAIL reload_mem1 got=%h want=8c120004", d); end
        start_load(6'd40);
        n_cmp++; if (err_o !== 1'b1 || done_o !== 1'b1 || cpu_rst_o !== 1'b0) begin n_fail++; $display("FAIL run_illegal err=%b done=%b cpu_rst=%b want 1/1/0", err_o, done_o, cpu_rst_o); end
        tick();
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL run_err_width got=%b want=0", err_o); end
    endtask

    task automatic test_illegal(input logic [5:0] cnt);
        start_load(cnt);
        n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL illegal%0d_err got=%b want=1", cnt, err_o); end
        n_cmp++; if (in_ready_o !== 1'b0 || busy_o !== 1'b0 || cpu_rst_o !== 1'b1) begin n_fail++; $display("FAIL illegal%0d_state in_ready=%b busy=%b cpu_rst=%b want 0/0/1", cnt, in_ready_o, busy_o, cpu_rst_o); end
        tick();
        n_cmp++; if (err_o !== 1'b0 || in_ready_o !== 1'b0) begin n_fail++; $display("FAIL illegal%0d_after err=%b in_ready=%b want 0/0", cnt, err_o, in_ready_o); end
    endtask

    task automatic test_throttled();
        logic [7:0]  bytes [4] = '{8'h00, 8'h00, 8'h00, 8'h20};
        logic [31:0] d;
        start_load(6'd1);
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i]);
            if (i < 3) begin
                repeat (3) tick();
                n_cmp++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin n_fail++; $display("FAIL thr_stall%0d busy=%b done=%b want 1/0", i, busy_o, done_o); end
            end
        end
        n_cmp++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL thr_done got=%b want=1", done_o); end
        for (int a = 0; a < 32; a++) begin
            read_word(32'(a), d);
            n_cmp++; if (d !== (a == 0 ? 32'h00000020 : 32'h0)) begin n_fail++; $display("FAIL thr_mem[%0d] got=%h", a, d); end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0]  bytes [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        logic [31:0] d;
        start_load(6'd1);
        send_byte(8'hEE);
        send_byte(8'hFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (in_ready_o !== 1'b0 || busy_o !== 1'b0 || cpu_rst_o !== 1'b1) begin n_fail++; $display("FAIL midrst_flags in_ready=%b busy=%b cpu_rst=%b want 0/0/1", in_ready_o, busy_o, cpu_rst_o); end
        for (int a = 0; a < 32; a++) begin
            read_word(32'(a), d);
            n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_mem[%0d] got=%h want=00000000", a, d); end
        end
        start_load(6'd1);
        for (int i = 0; i < 4; i++) send_byte(bytes[i]);
        n_cmp++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL midrst_done got=%b want=1", done_o); end
        read_word(32'd0, d);
        n_cmp++; if (d !== 32'h01020304) begin n_fail++; $display("FAIL midrst_mem0 got=%h want=01020304", d); end
    endtask

    task automatic test_full_load();
        logic [31:0] d;
        logic [7:0]  v;
        start_load(6'd32);
        for (int w = 0; w < 32; w++) begin
            v = 8'(w);
            send_byte(v); send_byte(8'h5A); send_byte(~v); send_byte(v + 8'h80);
            if (w == 30) begin
                n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL full_early_done got=%b want=0", done_o); end
            end
        end
        n_cmp++; if (done_o !== 1'b1 || in_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_done done=%b in_ready=%b want 1/0", done_o, in_ready_o); end
        read_word(32'd31, d);
        n_cmp++; if (d !== 32'h1F5AE09F) begin n_fail++; $display("FAIL full_mem31 got=%h want=1f5ae09f", d); end
        read_word(32'd0, d);
        n_cmp++; if (d !== 32'h005AFF80) begin n_fail++; $display("FAIL full_mem0 got=%h want=005aff80", d); end
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_reload();
        do_reset();
        test_illegal(6'd0);
        test_illegal(6'd33);
        test_throttled();
        test_reset_mid_load();
        test_full_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side companion to the single-cycle datapath's instruction memory. Receives a program as a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them into a 32-entry instruction store. Exposes the same clocked read port the datapath uses for instruction fetch. Holds the CPU in reset until a load completes.

## Interface
- DEPTH, 32, number of 32-bit instruction words; fixed at 32 for this design.
- ADDR_W, 5, word address width; equals log2(DEPTH).

- clock  input  1  system clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- load_start  input  1  one-cycle request to begin a load; sampled in IDLE and RUN only.
- load_count  input  6  number of words to load; legal range 1..32; sampled with load_start.
- in_valid  input  1  byte source has a byte on in_data.
- in_data  input  8  program byte; first byte of each word is bits 31:24.
- in_ready  output  1  loader accepts a byte this cycle; transfer when in_valid & in_ready.
- rd_addr  input  32  fetch address from the datapath PC; only rd_addr[4:0] used, as a word index.
- rd_instr  output  32  registered fetch data.
- cpu_rst  output  1  reset to the datapath; high except in RUN.
- busy  output  1  high in LOAD.
- done  output  1  high in RUN.
- err  output  1  one-cycle pulse on a rejected load_start.

## Operation
- States: IDLE, LOAD, RUN. All outputs registered.
- Reset (rst=1 at a posedge): state IDLE; all 32 entries cleared to 0x00000000 (nop); byte count, word pointer and word count cleared; rd_instr=0, in_ready=0, busy=0, done=0, err=0, cpu_rst=1. Takes priority over everything, including an in-progress load.
- IDLE: cpu_rst=1. load_start with load_count in 1..32 → LOAD; latch count, word pointer=0, byte count=0. load_start with load_count=0 or >32 → err pulses for one cycle, stay in IDLE.
- LOAD: in_ready=1, busy=1, cpu_rst=1. Each accepted byte shifts into the assembly register, MSB first. The byte count runs 0→3.
- On the 4th byte of a word: write the word to mem[pointer], increment the pointer, and clear the byte count.
- When the written word is the last one (pointer+1 == count): go to RUN on the same edge.
- load_start during LOAD is ignored.
- Stalls: in_valid low leaves all LOAD state unchanged. There is no timeout.
- RUN: cpu_rst=0, done=1, in_ready=0. Memory is not written. load_start with a legal count → LOAD (re-load); cpu_rst, busy and in_ready go high and done goes low after that edge. An illegal count → err pulse, stay in RUN.
- Entries at or beyond load_count keep their previous contents. They are not cleared.
- Read port: on every posedge in every state, rd_instr <= mem[rd_addr[4:0]].
- Read during a write to the same entry on the same edge returns the old contents.

## Timing
- load_start accepted at edge N: in_ready=1 from cycle N+1. The first byte can transfer at edge N+1.
- Minimum load time with in_valid held high: 4·count cycles after in_ready rises.
- The 4th byte of the last word is accepted at edge M. After edge M: state=RUN, cpu_rst=0, done=1, busy=0, in_ready=0. The data is readable via rd_instr from edge M+1.
- Fetch latency: 1 cycle (rd_addr at edge K → rd_instr valid after K).
- err: high for exactly the one cycle after the rejecting edge.

## Test plan
- Reset: assert rst for 2 cycles → cpu_rst=1, in_ready=0, done=0, busy=0, rd_instr=0; reading any address returns 0.
- Two-word load, count=2, bytes 8C 11 00 08 8C 12 00 04 back-to-back:
  - mem[0]=0x8C110008 and mem[1]=0x8C120004.
  - done=1 and cpu_rst=0 after the 8th byte edge.
  - rd_addr=1 → rd_instr=0x8C120004 one cycle later.
- Throttled source, count=1, bytes 00 00 00 20 with in_valid low for 3 cycles between each byte → mem[0]=0x00000020 and all other entries remain 0.
- Illegal count:
  - load_start with count=0 → 1-cycle err, stays in IDLE, in_ready stays 0.
  - load_start with count=33 → same result.
- Reload from RUN: count=1 with bytes AA BB CC DD → cpu_rst=1 the cycle after load_start; on completion mem[0]=0xAABBCCDD and mem[1] still 0x8C120004.
- Reset mid-LOAD: rst after 2 of 4 bytes → IDLE, memory all 0. A following count=1 load of 01 02 03 04 gives mem[0]=0x01020304, with no stale bytes.
